if_fetch_buffer: RTL

- In-order fetch buffer between the instruction-fetch stage and decode.
- Records each issued imem read address and pairs it with the returning imem response data.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Back-pressures fetch by asserting o_full, which drives the fetch stall. On a flush, it discards buffered and in-flight wrong-path instructions.

---
 rtl/if_fetch_buffer_if.sv | 25 ++
 rtl/if_fetch_buffer.sv | 104 ++++++++++
 2 files changed

// File: rtl/if_fetch_buffer_if.sv
// if_fetch_buffer_if: fetch/imem/decode signal bundle for the fetch buffer
//   master: drives requests, flush, imem responses and decode ready (fetch + imem + decode side)
//   slave : the fetch buffer; drives o_full and the decode head {o_valid, o_pc, o_instr}
interface if_fetch_buffer_if;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_flush;
    logic        i_imem_resp;
    logic [31:0] i_imem_rdata;
    logic        o_full;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        i_ready;

    modport master (
        output i_req_valid, i_req_addr, i_flush, i_imem_resp, i_imem_rdata, i_ready,
        input  o_full, o_valid, o_pc, o_instr
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_flush, i_imem_resp, i_imem_rdata, i_ready,
        output o_full, o_valid, o_pc, o_instr
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: in-order fetch buffer pairing imem read addresses with returning data
//   clk, rst : clock, synchronous active-high reset
//   bus      : if_fetch_buffer_if.slave (requests, flush, imem responses, decode handshake, o_full)
//   DEPTH    : total credits shared by pending requests and buffered instructions (power of two, >= 2)
//   IFB_BYPASS_EN : when defined, a current-epoch response into an empty buffer is presented
//                   to decode in the same cycle
module if_fetch_buffer #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    if_fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]   pq_addr [DEPTH];
    logic          pq_ep   [DEPTH];
    logic [31:0]   fa      [DEPTH];
    logic [31:0]   fd      [DEPTH];
    logic [PW-1:0] pw, pr, fw, fr;
    logic          epoch, full_q, valid_q;
    logic [31:0]   pc_q, instr_q;

    logic          epoch_n, resp_pop, resp_hit, fifo_push, fifo_pop, byp_take, new_head;
    logic [31:0]   head_addr;
    logic [PW-1:0] pw_n, pr_n, fw_n, fr_n, pend_cnt, fifo_cnt;
    logic [PW:0]   occ_n;
    logic [AW-1:0] head_idx;

    // A request in a flush cycle is the redirect target, so it already carries the new epoch.
    assign epoch_n   = epoch ^ bus.i_flush;
    assign resp_pop  = bus.i_imem_resp && (pw != pr);
    assign head_addr = pq_addr[pr[AW-1:0]];
    assign resp_hit  = resp_pop && (pq_ep[pr[AW-1:0]] == epoch) && !bus.i_flush;
    assign fifo_pop  = valid_q && bus.i_ready;
    assign fifo_push = resp_hit && !byp_take;

    assign pw_n = pw + PW'(bus.i_req_valid);
    assign pr_n = pr + PW'(resp_pop);
    assign fw_n = fw + PW'(fifo_push);
    // Flush never coincides with a push, so collapsing the read pointer empties the FIFO.
    assign fr_n = bus.i_flush ? fw : fr + PW'(fifo_pop);

    assign pend_cnt = pw_n - pr_n;
    assign fifo_cnt = fw_n - fr_n;
    assign occ_n    = {1'b0, pend_cnt} + {1'b0, fifo_cnt};

    // Next head is the slot being written this cycle when the FIFO drains to exactly that slot.
    assign head_idx = fr_n[AW-1:0];
    assign new_head = fifo_push && (fw[AW-1:0] == head_idx);

`ifdef IFB_BYPASS_EN
    logic byp;
    assign byp         = resp_hit && (fw == fr);
    assign byp_take    = byp && bus.i_ready;
    assign bus.o_valid = valid_q | byp;
    assign bus.o_pc    = byp ? head_addr : pc_q;
    assign bus.o_instr = byp ? bus.i_imem_rdata : instr_q;
`else
    assign byp_take    = 1'b0;
    assign bus.o_valid = valid_q;
    assign bus.o_pc    = pc_q;
    assign bus.o_instr = instr_q;
`endif
    assign bus.o_full = full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pw      <= '0;
            pr      <= '0;
            fw      <= '0;
            fr      <= '0;
            epoch   <= 1'b0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            pw      <= pw_n;
            pr      <= pr_n;
            fw      <= fw_n;
            fr      <= fr_n;
            epoch   <= epoch_n;
            full_q  <= (occ_n == (PW+1)'(DEPTH));
            valid_q <= (fw_n != fr_n);
            pc_q    <= new_head ? head_addr : fa[head_idx];
            instr_q <= new_head ? bus.i_imem_rdata : fd[head_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_req_valid) begin
            pq_addr[pw[AW-1:0]] <= bus.i_req_addr;
            pq_ep[pw[AW-1:0]]   <= epoch_n;
        end
        if (fifo_push) begin
            fa[fw[AW-1:0]] <= head_addr;
            fd[fw[AW-1:0]] <= bus.i_imem_rdata;
        end
    end

    a_no_req_when_full: assert property (@(posedge clk) disable iff (rst) bus.i_req_valid |-> !full_q);
endmodule
